camera_reg_cfg: RTL and testbench
=================================

// Module: camera_reg_cfg
// PURPOSE
//  Upstream sequencer for the camera I2C write engine. Walks a register table and issues one
//  24-bit write {dev_addr, reg, val} per entry through the start/tr_end/ack handshake.
//  Retries NACKed writes, then reports completion or error. Runs on the 20 kHz I2C clock.
// PARAMETERS
//  DEV_ADDR    8'h42  camera 8-bit write address (R/W bit = 0)
//  REG_NUM     8'd64  table entries; index range 0..REG_NUM-1
//  PWRUP_CYC   16'd400  clock_i2c cycles after reset/restart before first write (20 ms)
//  GAP_CYC     4      cycles i2c_start is held low between writes; minimum 2
//  MAX_RETRY   3      extra attempts per entry after a NACK
//  DLY_CYC     16'd100  wait length for a delay-marker entry (5 ms)
//  TIMEOUT_CYC 16'd64  tr_end watchdog; used only with CAM_CFG_TIMEOUT_EN
// PORTS
//  clock_i2c    in   1   I2C bit clock; all logic is on its rising edge
//  camera_rstn  in   1   asynchronous active-low reset
//  cfg_restart  in   1   one-cycle pulse: abort and rerun the whole table
//  i2c_start    out  1   to write engine start; low = engine reset, high = run one transfer
//  i2c_data     out  24  {DEV_ADDR, reg[7:0], val[7:0]}, stable while i2c_start=1
//  i2c_tr_end   in   1   engine transfer finished; held until i2c_start falls
//  i2c_ack      in   1   engine ack summary; 0 = all three bytes ACKed; valid when tr_end=1
//  cfg_index    out  8   entry currently being processed
//  cfg_done     out  1   sticky: table finished (with or without error)
//  cfg_err      out  1   sticky: an entry exhausted its retries or timed out
// BEHAVIOUR
//  Reset values: i2c_start=0, i2c_data=0, cfg_index=0, cfg_done=0, cfg_err=0, state=PWRUP.
//  Table entries are 16 bits {reg, val}. Two entries are special:
//   - 16'hFFFF: end marker.
//   - 16'hFFF0: delay marker.
//  Reaching index REG_NUM is also treated as the end marker.
//  States:
//   PWRUP: count PWRUP_CYC cycles with i2c_start=0, then go to LOAD.
//   LOAD: read entry[cfg_index].
//    - end marker -> DONE.
//    - delay marker -> DELAY.
//    - otherwise latch i2c_data and go to GAP.
//   GAP: i2c_start=0 for GAP_CYC cycles, then XFER. This guarantees the engine counter
//    restarts and the stale tr_end clears.
//   XFER: i2c_start=1. Wait for i2c_tr_end=1, then go to CHECK.
//    - Before GAP_CYC has elapsed, tr_end is ignored.
//   CHECK: i2c_start=0.
//    - i2c_ack=0: clear retry count, cfg_index+1, go to LOAD.
//    - i2c_ack=1 and retries<MAX_RETRY: retries+1, go to GAP with the same data.
//    - Otherwise: cfg_err=1, go to DONE.
//   DELAY: count DLY_CYC cycles, cfg_index+1, go to LOAD. No I2C traffic.
//   DONE: cfg_done=1, i2c_start=0. Hold until restart.
//  cfg_restart (any state, including mid-XFER):
//   - Next edge: i2c_start=0, cfg_index=0, cfg_done=0, cfg_err=0, retries=0, state=PWRUP.
//   - The engine aborts on start=0; the bus returns to idle within one cycle.
//  Simultaneous restart and tr_end: restart wins; the ack is discarded.
//  Counters are 16 bits and saturate. cfg_index is 8 bits and never wraps, because the
//  end check happens before the increment.
//  Per-write latency: GAP_CYC + 33 + 1 cycles (engine transfer is 33 cycles).
// CONFIGURATION
//  CAM_CFG_TIMEOUT_EN defined:
//   - XFER counts cycles. If tr_end is absent after TIMEOUT_CYC cycles, the attempt is
//     treated exactly as a NACK (same retry path).
//  CAM_CFG_TIMEOUT_EN undefined:
//   - XFER waits for tr_end indefinitely; TIMEOUT_CYC is unused; no watchdog counter exists.
// STRUCTURE
//  Shared package camera_cfg_pkg holds:
//   - state encoding (PWRUP, LOAD, GAP, XFER, CHECK, DELAY, DONE)
//   - CFG_END_MARK=16'hFFFF and CFG_DLY_MARK=16'hFFF0
//   - default DEV_ADDR
//  Sub-module camera_cfg_lut: combinational ROM, index[7:0] -> {reg, val}[15:0].
//   Camera-specific contents, swappable per sensor.
// TESTING
//  - Bench drives a behavioural engine model (33-cycle transfer, programmable ack).
//  1. 3-entry table {1280,1100,FFFF}, all ACK:
//     i2c_data=24'h421280 then 24'h421100; cfg_done=1, cfg_err=0, cfg_index=2.
//  2. Entry 0 NACKs twice then ACKs, MAX_RETRY=3:
//     exactly 3 start pulses with 24'h421280; cfg_err=0.
//  3. Entry 0 always NACKs:
//     4 start pulses, then cfg_done=1, cfg_err=1, cfg_index=0, i2c_start stays 0.
//  4. Table {1280,FFF0,1100,FFFF}:
//     gap between end of write 1 and start of write 2 >= DLY_CYC+GAP_CYC cycles.
//  5. cfg_restart mid-XFER of entry 1:
//     i2c_start=0 next edge; PWRUP_CYC idle; rerun begins at index 0 with 24'h421280.
//  6. CAM_CFG_TIMEOUT_EN, model never asserts tr_end:
//     each attempt lasts TIMEOUT_CYC; after 4 attempts cfg_err=1. Without the macro,
//     the block stays in XFER.

Source files
------------

// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the camera register-table sequencer: state encoding,
// table marker values, default device address and a saturating counter helper.
package camera_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_GAP,
    ST_XFER,
    ST_CHECK,
    ST_DELAY,
    ST_DONE
  } cfg_state_e;

  localparam logic [15:0] CFG_END_MARK = 16'hFFFF;
  localparam logic [15:0] CFG_DLY_MARK = 16'hFFF0;
  localparam logic [7:0]  CFG_DEV_ADDR = 8'h42;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/camera_cfg_lut.sv
// Combinational register table, index -> {reg, val}. Contents are sensor specific;
// LUT_SEL picks between the tables built into this file.
module camera_cfg_lut
  import camera_cfg_pkg::*;
#(
  parameter int unsigned LUT_SEL = 0
) (
  input  logic [7:0]  index_i,
  output logic [15:0] entry_o
);

  always_comb begin
    entry_o = CFG_END_MARK;
    if (LUT_SEL == 1) begin
      unique case (index_i)
        8'd0:    entry_o = 16'h1280;
        8'd1:    entry_o = CFG_DLY_MARK;
        8'd2:    entry_o = 16'h1100;
        default: entry_o = CFG_END_MARK;
      endcase
    end else begin
      unique case (index_i)
        8'd0:    entry_o = 16'h1280;
        8'd1:    entry_o = 16'h1100;
        default: entry_o = CFG_END_MARK;
      endcase
    end
  end

endmodule

// File: rtl/camera_reg_cfg.sv
// Camera register-table sequencer: issues one 24-bit write per table entry through the
// I2C engine start/tr_end/ack handshake, with NACK retries. Optional tr_end watchdog
// is enabled by defining CAM_CFG_TIMEOUT_EN.
module camera_reg_cfg
  import camera_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR  = CFG_DEV_ADDR,
  parameter logic [7:0]  REG_NUM   = 8'd64,
  parameter logic [15:0] PWRUP_CYC = 16'd400,
  parameter logic [15:0] GAP_CYC   = 16'd4,
  parameter logic [7:0]  MAX_RETRY = 8'd3,
  parameter logic [15:0] DLY_CYC   = 16'd100,
  parameter int unsigned LUT_SEL   = 0
`ifdef CAM_CFG_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT_CYC = 16'd64
`endif
) (
  input  logic        clock_i2c,
  input  logic        camera_rstn,
  input  logic        cfg_restart,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_tr_end,
  input  logic        i2c_ack,
  output logic [7:0]  cfg_index,
  output logic        cfg_done,
  output logic        cfg_err
);

  cfg_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [23:0] data_q, data_d;
  logic [7:0]  index_q, index_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        nack_q, nack_d;
  logic [15:0] entry;

  camera_cfg_lut #(.LUT_SEL(LUT_SEL)) u_lut (
    .index_i (index_q),
    .entry_o (entry)
  );

  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      retry_q <= '0;
      data_q  <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      index_q <= index_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    data_d  = data_q;
    index_d = index_q;
    done_d  = done_q;
    err_d   = err_q;
    start_d = 1'b0;
    nack_d  = nack_q;
    if (cfg_restart) begin
      // restart wins over a coincident tr_end; that ack is dropped
      state_d = ST_PWRUP;
      cnt_d   = '0;
      retry_d = '0;
      index_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PWRUP: begin
          if (cnt_q >= PWRUP_CYC - 16'd1) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
        ST_LOAD: begin
          cnt_d = '0;
          if (index_q >= REG_NUM || entry == CFG_END_MARK) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (entry == CFG_DLY_MARK) begin
            state_d = ST_DELAY;
          end else begin
            data_d  = {DEV_ADDR, entry};
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_q >= GAP_CYC - 16'd1) begin
            state_d = ST_XFER;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
        ST_XFER: begin
          start_d = 1'b1;
          cnt_d   = sat_inc16(cnt_q);
          // a tr_end inside the first GAP_CYC cycles is a leftover of the previous transfer
          if (i2c_tr_end && cnt_q >= GAP_CYC) begin
            nack_d  = i2c_ack;
            state_d = ST_CHECK;
            start_d = 1'b0;
            cnt_d   = '0;
          end
`ifdef CAM_CFG_TIMEOUT_EN
          else if (cnt_q >= TIMEOUT_CYC - 16'd1) begin
            nack_d  = 1'b1;
            state_d = ST_CHECK;
            start_d = 1'b0;
            cnt_d   = '0;
          end
`endif
        end
        ST_CHECK: begin
          if (!nack_q) begin
            retry_d = '0;
            index_d = index_q + 8'd1;
            state_d = ST_LOAD;
          end else if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DELAY: begin
          if (cnt_q >= DLY_CYC - 16'd1) begin
            cnt_d   = '0;
            index_d = index_q + 8'd1;
            state_d = ST_LOAD;
          end else begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: state_d = ST_PWRUP;
      endcase
    end
  end

  assign i2c_start = start_q;
  assign i2c_data  = data_q;
  assign cfg_index = index_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_camera_reg_cfg.sv
// Bench for camera_reg_cfg: two instances (plain table and delay-marker table), each
// driven by a behavioural 33-cycle I2C engine with a programmable NACK count.
module tb_camera_reg_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart [2];
  int unsigned nack_limit [2];
  bit          never_end [2];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_eng
    logic        start, tr_end, ack, done, err;
    logic [23:0] data;
    logic [7:0]  idx;
    logic        start_d1 = 1'b0;
    int unsigned cnt = 0;
    int unsigned attempt = 0;
    logic [31:0] rise_cnt = 0;
    logic [31:0] fall_cnt = 0;
    int unsigned last_rise = 0;
    int unsigned hi_len = 0;
    logic [23:0] data_log [64];
    int unsigned rise_log [64];
    int unsigned fall_log [64];

    camera_reg_cfg #(.LUT_SEL(g)) u_dut (
      .clock_i2c   (clk),
      .camera_rstn (rst_n),
      .cfg_restart (restart[g]),
      .i2c_start   (start),
      .i2c_data    (data),
      .i2c_tr_end  (tr_end),
      .i2c_ack     (ack),
      .cfg_index   (idx),
      .cfg_done    (done),
      .cfg_err     (err)
    );

    always @(posedge clk) begin
      start_d1 <= start;
      if (restart[g]) attempt <= 0;
      if (start && !start_d1) begin
        rise_cnt <= rise_cnt + 1;
        data_log[rise_cnt[5:0]] <= data;
        rise_log[rise_cnt[5:0]] <= cyc;
        last_rise <= cyc;
        attempt <= attempt + 1;
      end
      if (!start && start_d1) begin
        fall_cnt <= fall_cnt + 1;
        fall_log[fall_cnt[5:0]] <= cyc;
        hi_len <= cyc - last_rise;
      end
      if (!start) begin
        cnt <= 0;
        tr_end <= 1'b0;
        ack <= 1'b0;
      end else if (cnt < 33) begin
        cnt <= cnt + 1;
        if (cnt == 32 && !never_end[g]) begin
          tr_end <= 1'b1;
          ack <= (attempt <= nack_limit[g]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_restart0();
    @(negedge clk);
    restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
  endtask

  initial begin
    logic [31:0] base;
    int unsigned n;
    int unsigned hits;
    restart[0] = 1'b0;
    restart[1] = 1'b0;
    nack_limit[0] = 0;
    nack_limit[1] = 0;
    never_end[0] = 1'b0;
    never_end[1] = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, g_eng[0].start}, 0);
    check("rst_data", {8'd0, g_eng[0].data}, 0);
    check("rst_index", {24'd0, g_eng[0].idx}, 0);
    check("rst_done", {31'd0, g_eng[0].done}, 0);
    check("rst_err", {31'd0, g_eng[0].err}, 0);
    rst_n = 1'b1;

    // 1: three-entry table, all ACK
    for (int i = 0; i < 3000 && !g_eng[0].done; i++) @(negedge clk);
    check("t1_done", {31'd0, g_eng[0].done}, 1);
    check("t1_err", {31'd0, g_eng[0].err}, 0);
    check("t1_index", {24'd0, g_eng[0].idx}, 2);
    check("t1_writes", g_eng[0].rise_cnt, 2);
    check("t1_data0", {8'd0, g_eng[0].data_log[0]}, 32'h421280);
    check("t1_data1", {8'd0, g_eng[0].data_log[1]}, 32'h421100);
    check("t1_hi_len", g_eng[0].hi_len, 34);
    check("t1_start_low", {31'd0, g_eng[0].start}, 0);

    // 4: delay marker between writes (second instance)
    for (int i = 0; i < 3000 && !g_eng[1].done; i++) @(negedge clk);
    check("t4_done", {31'd0, g_eng[1].done}, 1);
    check("t4_err", {31'd0, g_eng[1].err}, 0);
    check("t4_index", {24'd0, g_eng[1].idx}, 3);
    check("t4_writes", g_eng[1].rise_cnt, 2);
    check("t4_data1", {8'd0, g_eng[1].data_log[1]}, 32'h421100);
    check("t4_gap_ge_104", {31'd0, (g_eng[1].rise_log[1] - g_eng[1].fall_log[0]) >= 104}, 1);

    // 2: entry 0 NACKs twice, then ACKs
    nack_limit[0] = 2;
    pulse_restart0();
    check("t2_done_cleared", {31'd0, g_eng[0].done}, 0);
    base = g_eng[0].rise_cnt;
    for (int i = 0; i < 4000 && !g_eng[0].done; i++) @(negedge clk);
    hits = 0;
    for (int unsigned k = base; k < g_eng[0].rise_cnt; k++)
      if (g_eng[0].data_log[k % 64] == 24'h421280) hits++;
    check("t2_done", {31'd0, g_eng[0].done}, 1);
    check("t2_pulses_e0", hits, 3);
    check("t2_pulses_all", g_eng[0].rise_cnt - base, 4);
    check("t2_err", {31'd0, g_eng[0].err}, 0);

    // 3: entry 0 always NACKs
    nack_limit[0] = 1000;
    pulse_restart0();
    check("t3_index_cleared", {24'd0, g_eng[0].idx}, 0);
    base = g_eng[0].rise_cnt;
    for (int i = 0; i < 4000 && !g_eng[0].done; i++) @(negedge clk);
    check("t3_done", {31'd0, g_eng[0].done}, 1);
    check("t3_err", {31'd0, g_eng[0].err}, 1);
    check("t3_index", {24'd0, g_eng[0].idx}, 0);
    check("t3_pulses", g_eng[0].rise_cnt - base, 4);
    repeat (50) @(negedge clk);
    check("t3_start_stays_low", {31'd0, g_eng[0].start}, 0);
    check("t3_no_more_pulses", g_eng[0].rise_cnt - base, 4);

    // 5: restart in the middle of entry 1's transfer
    nack_limit[0] = 0;
    pulse_restart0();
    check("t5_err_cleared", {31'd0, g_eng[0].err}, 0);
    base = g_eng[0].rise_cnt;
    for (int i = 0; i < 3000 && g_eng[0].rise_cnt < base + 2; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("t5_mid_start", {31'd0, g_eng[0].start}, 1);
    check("t5_mid_index", {24'd0, g_eng[0].idx}, 1);
    restart[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t5_abort_start", {31'd0, g_eng[0].start}, 0);
    check("t5_abort_index", {24'd0, g_eng[0].idx}, 0);
    @(negedge clk);
    restart[0] = 1'b0;
    n = 0;
    while (!g_eng[0].start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_restarted", {31'd0, g_eng[0].start}, 1);
    check("t5_pwrup_idle", {31'd0, n >= 400}, 1);
    check("t5_rerun_data", {8'd0, g_eng[0].data}, 32'h421280);
    check("t5_rerun_index", {24'd0, g_eng[0].idx}, 0);

    // 6: engine never signals tr_end
    for (int i = 0; i < 3000 && !g_eng[0].done; i++) @(negedge clk);
    never_end[0] = 1'b1;
    pulse_restart0();
    base = g_eng[0].rise_cnt;
`ifdef CAM_CFG_TIMEOUT_EN
    for (int i = 0; i < 3000 && !g_eng[0].done; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t6_done", {31'd0, g_eng[0].done}, 1);
    check("t6_err", {31'd0, g_eng[0].err}, 1);
    check("t6_attempts", g_eng[0].rise_cnt - base, 4);
    check("t6_attempt_len", g_eng[0].hi_len, 64);
    check("t6_index", {24'd0, g_eng[0].idx}, 0);
`else
    repeat (1500) @(negedge clk);
    check("t6_stuck_start", {31'd0, g_eng[0].start}, 1);
    check("t6_stuck_done", {31'd0, g_eng[0].done}, 0);
    check("t6_stuck_pulses", g_eng[0].rise_cnt - base, 1);
    check("t6_stuck_index", {24'd0, g_eng[0].idx}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
